// File: rtl/segment7_scan.sv
// Multiplexed seven-segment display driver with a decimal/hex up-counter.
// A tick divider advances the count; a scan divider rotates the active digit.
module segment7_scan #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned TICK_DIV   = 1000000,
  parameter int unsigned SCAN_DIV   = 1000
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    count_en,
  input  logic                    dec_mode,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_value,
  input  logic                    blank_lz,
  output logic [6:0]              led_out,
  output logic [6:0]              led_out_b,
  output logic [NUM_DIGITS-1:0]   dig_sel,
  output logic [4*NUM_DIGITS-1:0] value,
  output logic                    wrap
);

  localparam int unsigned VAL_W  = 4 * NUM_DIGITS;
  localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [TICK_W-1:0]     tick_cnt_q, tick_cnt_d;
  logic [SCAN_W-1:0]     scan_cnt_q, scan_cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [VAL_W-1:0]      count_q, count_d;
  logic                  wrap_q, wrap_d;
  logic [6:0]            led_out_q, led_out_d;
  logic [6:0]            led_out_b_q, led_out_b_d;
  logic [NUM_DIGITS-1:0] dig_sel_q, dig_sel_d;

  logic                  tick_c;
  logic                  scan_end_c;
  logic [VAL_W-1:0]      count_inc_c;
  logic                  carry_c;
  logic [3:0]            nib_c;
  logic                  at_max_c;
  logic [NUM_DIGITS-1:0] lead_zero_c;
  logic                  zero_above_c;
  logic [3:0]            cur_nib_c;
  logic                  cur_blank_c;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 7'h3F;
      4'h1: seg7 = 7'h06;
      4'h2: seg7 = 7'h5B;
      4'h3: seg7 = 7'h4F;
      4'h4: seg7 = 7'h66;
      4'h5: seg7 = 7'h6D;
      4'h6: seg7 = 7'h7D;
      4'h7: seg7 = 7'h07;
      4'h8: seg7 = 7'h7F;
      4'h9: seg7 = 7'h6F;
      4'hA: seg7 = 7'h77;
      4'hB: seg7 = 7'h7C;
      4'hC: seg7 = 7'h39;
      4'hD: seg7 = 7'h5E;
      4'hE: seg7 = 7'h79;
      default: seg7 = 7'h71;
    endcase
  endfunction

  // Tick divider: free counts only while enabled.
  always_comb begin
    tick_c     = count_en && (tick_cnt_q == TICK_W'(TICK_DIV - 1));
    tick_cnt_d = tick_cnt_q;
    if (count_en) begin
      tick_cnt_d = tick_c ? '0 : tick_cnt_q + TICK_W'(1);
    end
  end

  // Ripple increment; in decimal mode any nibble >= 9 rolls over and carries.
  always_comb begin
    count_inc_c = count_q;
    carry_c     = 1'b1;
    nib_c       = '0;
    at_max_c    = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      nib_c    = count_q[4*k +: 4];
      at_max_c = dec_mode ? (nib_c >= 4'd9) : (nib_c == 4'hF);
      if (carry_c) begin
        if (at_max_c) begin
          count_inc_c[4*k +: 4] = 4'h0;
        end else begin
          count_inc_c[4*k +: 4] = nib_c + 4'd1;
          carry_c               = 1'b0;
        end
      end
    end
  end

  // Load wins over a coincident tick and never reports a wrap.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (load) begin
      count_d = load_value;
    end else if (tick_c) begin
      count_d = count_inc_c;
      wrap_d  = carry_c;
    end
  end

  always_comb begin
    scan_end_c = (scan_cnt_q == SCAN_W'(SCAN_DIV - 1));
    scan_cnt_d = scan_end_c ? '0 : scan_cnt_q + SCAN_W'(1);
    idx_d      = idx_q;
    if (scan_end_c) begin
      idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end
  end

  // Digit k > 0 is a leading zero when it and every higher digit are zero.
  always_comb begin
    lead_zero_c  = '0;
    zero_above_c = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_above_c   = zero_above_c && (count_q[4*k +: 4] == 4'h0);
      lead_zero_c[k] = zero_above_c && (k != 0);
    end
  end

  // Select and pattern come from the same index so they always match.
  always_comb begin
    cur_nib_c   = '0;
    cur_blank_c = 1'b0;
    dig_sel_d   = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        cur_nib_c    = count_q[4*k +: 4];
        cur_blank_c  = lead_zero_c[k];
        dig_sel_d[k] = 1'b1;
      end
    end
    led_out_d   = (blank_lz && cur_blank_c) ? 7'h00 : seg7(cur_nib_c);
    led_out_b_d = 7'h00;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt_q  <= '0;
      scan_cnt_q  <= '0;
      idx_q       <= '0;
      count_q     <= '0;
      wrap_q      <= 1'b0;
      led_out_q   <= 7'h00;
      led_out_b_q <= 7'h7F;
      dig_sel_q   <= '0;
    end else begin
      tick_cnt_q  <= tick_cnt_d;
      scan_cnt_q  <= scan_cnt_d;
      idx_q       <= idx_d;
      count_q     <= count_d;
      wrap_q      <= wrap_d;
      led_out_q   <= led_out_d;
      led_out_b_q <= led_out_b_d;
      dig_sel_q   <= dig_sel_d;
    end
  end

  assign led_out   = led_out_q;
  assign led_out_b = led_out_b_q;
  assign dig_sel   = dig_sel_q;
  assign value     = count_q;
  assign wrap      = wrap_q;

endmodule

// File: tb/tb_segment7_scan.sv
// Scoreboard bench for segment7_scan (4 digits, tick every 4, scan slot of 2).
module tb_segment7_scan;

  logic        clk;
  logic        reset_n;
  logic        count_en;
  logic        dec_mode;
  logic        load;
  logic [15:0] load_value;
  logic        blank_lz;
  logic [6:0]  led_out;
  logic [6:0]  led_out_b;
  logic [3:0]  dig_sel;
  logic [15:0] value;
  logic        wrap;

  segment7_scan #(.NUM_DIGITS(4), .TICK_DIV(4), .SCAN_DIV(2)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .count_en   (count_en),
    .dec_mode   (dec_mode),
    .load       (load),
    .load_value (load_value),
    .blank_lz   (blank_lz),
    .led_out    (led_out),
    .led_out_b  (led_out_b),
    .dig_sel    (dig_sel),
    .value      (value),
    .wrap       (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    string       tag;
    bit          cv;
    logic [15:0] v;
    bit          cd;
    logic [3:0]  sel;
    logic [6:0]  led;
    bit          cw;
    logic        w;
  } exp_t;

  exp_t sb_q[$];
  exp_t me;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   wrap_seen = 0;

  // Edge count since the last reset release; edge 1 is the first posedge.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void push(input int c, input string tag,
                               input bit cv, input logic [15:0] v,
                               input bit cd, input logic [3:0] sel, input logic [6:0] led,
                               input bit cw, input logic w);
    exp_t e;
    e.cyc = c; e.tag = tag; e.cv = cv; e.v = v; e.cd = cd;
    e.sel = sel; e.led = led; e.cw = cw; e.w = w;
    sb_q.push_back(e);
  endfunction

  // Monitor: at each falling edge, compare every entry due on this cycle.
  always @(negedge clk) begin
    if (wrap === 1'b1) wrap_seen++;
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      me = sb_q.pop_front();
      if (me.cyc != cyc) chk($sformatf("%s@%0d.late", me.tag, me.cyc), 32'(cyc), 32'(me.cyc));
      chk($sformatf("%s@%0d.led_out_b", me.tag, me.cyc), 32'(led_out_b), 32'h00);
      if (me.cv) chk($sformatf("%s@%0d.value", me.tag, me.cyc), 32'(value), 32'(me.v));
      if (me.cd) begin
        chk($sformatf("%s@%0d.dig_sel", me.tag, me.cyc), 32'(dig_sel), 32'(me.sel));
        chk($sformatf("%s@%0d.led_out", me.tag, me.cyc), 32'(led_out), 32'(me.led));
      end
      if (me.cw) chk($sformatf("%s@%0d.wrap", me.tag, me.cyc), 32'(wrap), 32'(me.w));
    end
  end

  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain(input string tag);
    int k = 0;
    while (sb_q.size() > 0 && k < 100) begin
      @(posedge clk);
      k++;
    end
    chk({tag, ".drain"}, 32'(sb_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, ".rst_value"},     32'(value),     32'h0000);
    chk({tag, ".rst_dig_sel"},   32'(dig_sel),   32'h0);
    chk({tag, ".rst_led_out"},   32'(led_out),   32'h00);
    chk({tag, ".rst_led_out_b"}, 32'(led_out_b), 32'h7F);
    chk({tag, ".rst_wrap"},      32'(wrap),      32'h0);
  endtask

  // Inputs are set by the caller before this; release lands on a falling edge.
  task automatic do_reset(input string tag);
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check_reset_state(tag);
    reset_n = 1'b1;
    #1;
    chk({tag, ".oeb_before_edge"}, 32'(led_out_b), 32'h7F);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, tests %0d", n_tests);
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0; count_en = 1'b0; dec_mode = 1'b0; load = 1'b0;
    load_value = 16'h0000; blank_lz = 1'b0;

    // Idle after reset: all zeros shown, scan 1,1,2,2,4,4,8,8.
    do_reset("idle");
    push(1, "idle", 1, 16'h0000, 1, 4'h1, 7'h3F, 1, 1'b0);
    push(2, "idle", 1, 16'h0000, 1, 4'h1, 7'h3F, 0, 1'b0);
    push(3, "idle", 1, 16'h0000, 1, 4'h2, 7'h3F, 0, 1'b0);
    push(4, "idle", 0, 16'h0000, 1, 4'h2, 7'h3F, 0, 1'b0);
    push(5, "idle", 0, 16'h0000, 1, 4'h4, 7'h3F, 0, 1'b0);
    push(6, "idle", 0, 16'h0000, 1, 4'h4, 7'h3F, 0, 1'b0);
    push(7, "idle", 0, 16'h0000, 1, 4'h8, 7'h3F, 0, 1'b0);
    push(8, "idle", 1, 16'h0000, 1, 4'h8, 7'h3F, 0, 1'b0);
    wait_cyc(8);
    drain("idle");

    // 0099 decimal -> 0100, then leading-zero blanking.
    dec_mode = 1'b1; count_en = 1'b1; load = 1'b1; load_value = 16'h0099; blank_lz = 1'b0;
    do_reset("d99");
    push(1,  "d99", 1, 16'h0099, 0, 4'h0, 7'h00, 1, 1'b0);
    push(3,  "d99", 1, 16'h0099, 1, 4'h2, 7'h6F, 0, 1'b0);
    push(4,  "d99", 1, 16'h0100, 1, 4'h2, 7'h6F, 1, 1'b0);
    push(5,  "d99", 1, 16'h0100, 1, 4'h4, 7'h06, 0, 1'b0);
    push(7,  "d99", 0, 16'h0000, 1, 4'h8, 7'h3F, 0, 1'b0);
    push(9,  "d99", 0, 16'h0000, 1, 4'h1, 7'h3F, 0, 1'b0);
    push(11, "d99", 0, 16'h0000, 1, 4'h2, 7'h3F, 0, 1'b0);
    push(13, "d99b", 0, 16'h0000, 1, 4'h4, 7'h06, 0, 1'b0);
    push(15, "d99b", 0, 16'h0000, 1, 4'h8, 7'h00, 0, 1'b0);
    push(17, "d99b", 0, 16'h0000, 1, 4'h1, 7'h3F, 0, 1'b0);
    push(19, "d99b", 1, 16'h0100, 1, 4'h2, 7'h3F, 0, 1'b0);
    wait_cyc(1);  load = 1'b0;
    wait_cyc(4);  count_en = 1'b0;
    wait_cyc(12); blank_lz = 1'b1;
    wait_cyc(19);
    drain("d99");
    blank_lz = 1'b0;

    // Full rollover in decimal mode.
    dec_mode = 1'b1; count_en = 1'b1; load = 1'b1; load_value = 16'h9999;
    do_reset("w9999");
    push(1, "w9999", 1, 16'h9999, 0, 4'h0, 7'h00, 1, 1'b0);
    push(3, "w9999", 1, 16'h9999, 0, 4'h0, 7'h00, 1, 1'b0);
    push(4, "w9999", 1, 16'h0000, 0, 4'h0, 7'h00, 1, 1'b1);
    push(5, "w9999", 1, 16'h0000, 0, 4'h0, 7'h00, 1, 1'b0);
    wait_cyc(1); load = 1'b0;
    wait_cyc(4); count_en = 1'b0;
    wait_cyc(5);
    drain("w9999");

    // Full rollover in hex mode.
    dec_mode = 1'b0; count_en = 1'b1; load = 1'b1; load_value = 16'hFFFF;
    do_reset("wffff");
    push(1, "wffff", 1, 16'hFFFF, 0, 4'h0, 7'h00, 1, 1'b0);
    push(3, "wffff", 1, 16'hFFFF, 0, 4'h0, 7'h00, 1, 1'b0);
    push(4, "wffff", 1, 16'h0000, 0, 4'h0, 7'h00, 1, 1'b1);
    push(5, "wffff", 1, 16'h0000, 0, 4'h0, 7'h00, 1, 1'b0);
    wait_cyc(1); load = 1'b0;
    wait_cyc(4); count_en = 1'b0;
    wait_cyc(5);
    drain("wffff");

    // Illegal decimal digit C acts as maximum; hex mode just increments it.
    dec_mode = 1'b1; count_en = 1'b1; load = 1'b1; load_value = 16'h000C;
    do_reset("dC");
    push(3, "dC", 1, 16'h000C, 0, 4'h0, 7'h00, 0, 1'b0);
    push(4, "dC", 1, 16'h0010, 0, 4'h0, 7'h00, 1, 1'b0);
    wait_cyc(1); load = 1'b0;
    wait_cyc(4); count_en = 1'b0;
    drain("dC");

    dec_mode = 1'b0; count_en = 1'b1; load = 1'b1; load_value = 16'h000C;
    do_reset("hC");
    push(4, "hC", 1, 16'h000D, 0, 4'h0, 7'h00, 1, 1'b0);
    wait_cyc(1); load = 1'b0;
    wait_cyc(4); count_en = 1'b0;
    drain("hC");

    // Load coincident with a tick wins; tick counter keeps its phase.
    dec_mode = 1'b0; count_en = 1'b1; load = 1'b0; load_value = 16'h0000;
    do_reset("ldtick");
    push(3,  "ldtick", 1, 16'h0000, 0, 4'h0, 7'h00, 0, 1'b0);
    push(4,  "ldtick", 1, 16'h0001, 0, 4'h0, 7'h00, 0, 1'b0);
    push(7,  "ldtick", 1, 16'h0001, 0, 4'h0, 7'h00, 0, 1'b0);
    push(8,  "ldtick", 1, 16'h1234, 0, 4'h0, 7'h00, 1, 1'b0);
    push(11, "ldtick", 1, 16'h1234, 0, 4'h0, 7'h00, 0, 1'b0);
    push(12, "ldtick", 1, 16'h1235, 0, 4'h0, 7'h00, 0, 1'b0);
    wait_cyc(7);  load = 1'b1; load_value = 16'h1234;
    wait_cyc(8);  load = 1'b0;
    wait_cyc(12); count_en = 1'b0;
    drain("ldtick");

    // Asynchronous reset mid-scan with 4321 displayed.
    dec_mode = 1'b0; count_en = 1'b0; load = 1'b1; load_value = 16'h4321;
    do_reset("r4321");
    push(1, "r4321", 1, 16'h4321, 1, 4'h1, 7'h3F, 0, 1'b0);
    push(3, "r4321", 1, 16'h4321, 1, 4'h2, 7'h5B, 0, 1'b0);
    push(5, "r4321", 1, 16'h4321, 1, 4'h4, 7'h4F, 0, 1'b0);
    push(6, "r4321", 1, 16'h4321, 1, 4'h4, 7'h4F, 0, 1'b0);
    wait_cyc(1); load = 1'b0;
    wait_cyc(6);
    #5;
    reset_n = 1'b0;
    #1;
    check_reset_state("r4321_mid");
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    push(1, "r4321_post", 1, 16'h0000, 1, 4'h1, 7'h3F, 1, 1'b0);
    push(2, "r4321_post", 1, 16'h0000, 0, 4'h0, 7'h00, 1, 1'b0);
    wait_cyc(2);
    drain("r4321");

    // Reset one cycle before a 9999 rollover must not produce a wrap.
    dec_mode = 1'b1; count_en = 1'b1; load = 1'b1; load_value = 16'h9999;
    do_reset("rnowrap");
    wait_cyc(1); load = 1'b0;
    wait_cyc(3);
    #2;
    reset_n = 1'b0;
    count_en = 1'b0;
    #1;
    chk("rnowrap.mid_value", 32'(value), 32'h0000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    push(1, "rnowrap_post", 1, 16'h0000, 0, 4'h0, 7'h00, 1, 1'b0);
    push(3, "rnowrap_post", 1, 16'h0000, 0, 4'h0, 7'h00, 1, 1'b0);
    wait_cyc(3);
    drain("rnowrap");

    chk("wrap_pulse_count", 32'(wrap_seen), 32'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
